// File: rtl/mtc_pkg.sv
// ---------------------------------------------------------------------------
// mtc_pkg
// Shared types and default constants for the microtile switch controller.
//   mtc_state_t      : switch state machine encoding (RUN / QUIESCE / RESET)
//   MTC_*_DEF        : default parameter values used by the top level
//   mtc_sel_valid()  : true when a requested tile index addresses a real tile
// ---------------------------------------------------------------------------
package mtc_pkg;

    typedef enum logic [1:0] {
        MTC_RUN     = 2'd0,
        MTC_QUIESCE = 2'd1,
        MTC_RESET   = 2'd2
    } mtc_state_t;

    localparam int MTC_NUM_TILES_DEF   = 4;
    localparam int MTC_RST_CYCLES_DEF  = 4;
    localparam int MTC_SYNC_STAGES_DEF = 2;

    // Requests at or above the tile count are ignored by the controller.
    function automatic logic mtc_sel_valid(input int sel, input int num_tiles);
        return (sel < num_tiles);
    endfunction

endpackage

// File: rtl/mtc_sync.sv
// ---------------------------------------------------------------------------
// mtc_sync
// STAGES-deep, WIDTH-wide flop synchroniser with asynchronous active-low
// reset; all stages clear to zero.
//   clk   in   clock of the receiving domain
//   rst_n in   asynchronous active-low reset
//   d     in   WIDTH  asynchronous input
//   q     out  WIDTH  synchronised output (last stage)
// ---------------------------------------------------------------------------
module mtc_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/microtile_switch_ctrl.sv
// ---------------------------------------------------------------------------
// microtile_switch_ctrl
// Selects one of NUM_TILES microtiles. On a selection change all tile clocks
// stop for one cycle (QUIESCE), then the new tile is clocked but held in
// reset for RST_CYCLES cycles (RESET) before it runs (RUN).
//   clk, rst_n   clock, asynchronous active-low reset
//   sel_in       requested tile index (asynchronous, synchronised here)
//   ui_in        shared input bus, forwarded only to the running tile
//   tile_uo      packed tile outputs, tile i at [i*OUT_W +: OUT_W]
//   tile_ui      packed per-tile inputs, same packing
//   tile_rst_n   per-tile active-low reset
//   tile_clk_en  per-tile clock enable for external gating cells
//   uo_out       output of the running tile, 0 while switching
//   active_sel   current / target tile index
//   switching    high whenever the state is not RUN
// Build option: define MTC_OUT_REG_EN to register uo_out (one cycle latency,
// reset value 0); otherwise uo_out is combinational.
// ---------------------------------------------------------------------------
module microtile_switch_ctrl
    import mtc_pkg::*;
#(
    parameter int NUM_TILES   = MTC_NUM_TILES_DEF,
    parameter int SEL_W       = (NUM_TILES <= 2) ? 1 : $clog2(NUM_TILES),
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int RST_CYCLES  = MTC_RST_CYCLES_DEF,
    parameter int SYNC_STAGES = MTC_SYNC_STAGES_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEL_W-1:0]           sel_in,
    input  logic [IN_W-1:0]            ui_in,
    input  logic [NUM_TILES*OUT_W-1:0] tile_uo,
    output logic [NUM_TILES*IN_W-1:0]  tile_ui,
    output logic [NUM_TILES-1:0]       tile_rst_n,
    output logic [NUM_TILES-1:0]       tile_clk_en,
    output logic [OUT_W-1:0]           uo_out,
    output logic [SEL_W-1:0]           active_sel,
    output logic                       switching
);

    localparam logic [7:0] RST_INIT = 8'(RST_CYCLES - 1);

    logic [SEL_W-1:0] sel_sync_s;
    logic             sel_valid_s;

    mtc_state_t       state_q,      state_d;
    logic [SEL_W-1:0] active_sel_q, active_sel_d;
    logic [SEL_W-1:0] target_q,     target_d;
    logic [7:0]       rcnt_q,       rcnt_d;

    logic [OUT_W-1:0] uo_mux_s;

    mtc_sync #(
        .WIDTH  (SEL_W),
        .STAGES (SYNC_STAGES)
    ) u_sel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sel_in),
        .q     (sel_sync_s)
    );

    assign sel_valid_s = mtc_sel_valid(int'(sel_sync_s), NUM_TILES);

    // Next-state logic; requests are only sampled in RUN so a switch in
    // progress always completes before a new one is considered.
    always_comb begin
        state_d      = state_q;
        active_sel_d = active_sel_q;
        target_d     = target_q;
        rcnt_d       = rcnt_q;
        case (state_q)
            MTC_RUN: begin
                if ((sel_sync_s != active_sel_q) && sel_valid_s) begin
                    state_d  = MTC_QUIESCE;
                    target_d = sel_sync_s;
                end else begin
                    state_d  = MTC_RUN;
                end
            end
            MTC_QUIESCE: begin
                state_d      = MTC_RESET;
                active_sel_d = target_q;
                rcnt_d       = RST_INIT;
            end
            MTC_RESET: begin
                if (rcnt_q == 8'd0) begin
                    state_d = MTC_RUN;
                end else begin
                    rcnt_d  = rcnt_q - 8'd1;
                end
            end
            default: begin
                // Illegal encoding: fall back to resetting tile 0.
                state_d      = MTC_RESET;
                active_sel_d = {SEL_W{1'b0}};
                rcnt_d       = RST_INIT;
            end
        endcase
    end

    // Switch state machine registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MTC_RESET;
            active_sel_q <= {SEL_W{1'b0}};
            target_q     <= {SEL_W{1'b0}};
            rcnt_q       <= RST_INIT;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            target_q     <= target_d;
            rcnt_q       <= rcnt_d;
        end
    end

    // Per-tile decode from the state flops only, plus the RUN-gated output mux.
    always_comb begin
        tile_rst_n  = {NUM_TILES{1'b0}};
        tile_clk_en = {NUM_TILES{1'b0}};
        tile_ui     = {(NUM_TILES*IN_W){1'b0}};
        uo_mux_s    = {OUT_W{1'b0}};
        for (int i = 0; i < NUM_TILES; i++) begin
            if (active_sel_q == SEL_W'(i)) begin
                tile_rst_n[i]  = (state_q == MTC_RUN);
                tile_clk_en[i] = (state_q != MTC_QUIESCE);
                if (state_q == MTC_RUN) begin
                    tile_ui[i*IN_W +: IN_W] = ui_in;
                    uo_mux_s                = tile_uo[i*OUT_W +: OUT_W];
                end else begin
                    tile_ui[i*IN_W +: IN_W] = {IN_W{1'b0}};
                end
            end else begin
                tile_rst_n[i]  = 1'b0;
                tile_clk_en[i] = 1'b0;
            end
        end
    end

    assign active_sel = active_sel_q;
    assign switching  = (state_q != MTC_RUN);

`ifdef MTC_OUT_REG_EN
    logic [OUT_W-1:0] uo_q;

    // Output register: one cycle behind the gated mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_q <= {OUT_W{1'b0}};
        end else begin
            uo_q <= uo_mux_s;
        end
    end

    assign uo_out = uo_q;
`else
    assign uo_out = uo_mux_s;
`endif

endmodule

// File: tb/tb_microtile_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_microtile_switch_ctrl
// Directed bench for microtile_switch_ctrl with five tiles (SEL_W=3) so that
// out-of-range requests can be exercised. Expected per-cycle outputs are
// queued when stimulus is applied and popped on each falling clock edge.
// ---------------------------------------------------------------------------
module tb_microtile_switch_ctrl;

    localparam int NT = 5;
    localparam int SW = 3;
    localparam int IW = 8;
    localparam int OW = 8;
    localparam int RC = 4;
    localparam int SS = 2;

    localparam int K_RUN   = 0;
    localparam int K_QUI   = 1;
    localparam int K_RESET = 2;

    typedef struct {
        logic [NT-1:0] rst;
        logic [NT-1:0] cen;
        logic          sw;
        logic [SW-1:0] act;
        logic          run;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [SW-1:0]     sel_in;
    logic [IW-1:0]     ui_in;
    logic [NT*OW-1:0]  tile_uo;
    logic [NT*IW-1:0]  tile_ui;
    logic [NT-1:0]     tile_rst_n;
    logic [NT-1:0]     tile_clk_en;
    logic [OW-1:0]     uo_out;
    logic [SW-1:0]     active_sel;
    logic              switching;

    exp_t q[$];
    exp_t prev_e;
    int   tests;
    int   failed;

    microtile_switch_ctrl #(
        .NUM_TILES   (NT),
        .SEL_W       (SW),
        .IN_W        (IW),
        .OUT_W       (OW),
        .RST_CYCLES  (RC),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_in      (sel_in),
        .ui_in       (ui_in),
        .tile_uo     (tile_uo),
        .tile_ui     (tile_ui),
        .tile_rst_n  (tile_rst_n),
        .tile_clk_en (tile_clk_en),
        .uo_out      (uo_out),
        .active_sel  (active_sel),
        .switching   (switching)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int kind, input int t);
        exp_t e;
        logic [NT-1:0] oh;
        oh = 5'b00001 << t;
        e.act = SW'(t);
        case (kind)
            K_RUN:   begin e.rst = oh;    e.cen = oh;    e.sw = 1'b0; e.run = 1'b1; end
            K_QUI:   begin e.rst = 5'd0;  e.cen = 5'd0;  e.sw = 1'b1; e.run = 1'b0; end
            default: begin e.rst = 5'd0;  e.cen = oh;    e.sw = 1'b1; e.run = 1'b0; end
        endcase
        return e;
    endfunction

    task automatic push(input int kind, input int t, input int n);
        repeat (n) q.push_back(mk(kind, t));
    endtask

    function automatic logic [OW-1:0] gated(input exp_t e);
        logic [OW-1:0] v;
        v = 8'h00;
        if (e.run) v = tile_uo[int'(e.act)*OW +: OW];
        return v;
    endfunction

    // Pop and compare one expected entry per cycle until the queue is empty.
    task automatic drain();
        exp_t e;
        logic [NT*IW-1:0] ui_exp;
        logic [OW-1:0]    uo_exp;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            ui_exp = '0;
            for (int i = 0; i < NT; i++) begin
                if (e.rst[i]) ui_exp[i*IW +: IW] = ui_in;
            end
`ifdef MTC_OUT_REG_EN
            uo_exp = gated(prev_e);
`else
            uo_exp = gated(e);
`endif
            chk("tile_rst_n",  64'(tile_rst_n),  64'(e.rst));
            chk("tile_clk_en", 64'(tile_clk_en), 64'(e.cen));
            chk("switching",   64'(switching),   64'(e.sw));
            chk("active_sel",  64'(active_sel),  64'(e.act));
            chk("tile_ui",     64'(tile_ui),     64'(ui_exp));
            chk("uo_out",      64'(uo_out),      64'(uo_exp));
            prev_e = e;
        end
    endtask

    task automatic chk_reset();
        chk("rst_tile_rst_n",  64'(tile_rst_n),  64'(5'b00000));
        chk("rst_tile_clk_en", 64'(tile_clk_en), 64'(5'b00001));
        chk("rst_switching",   64'(switching),   64'(1'b1));
        chk("rst_active_sel",  64'(active_sel),  64'(3'd0));
        chk("rst_uo_out",      64'(uo_out),      64'(8'h00));
        chk("rst_tile_ui",     64'(tile_ui),     64'(40'h0));
    endtask

    initial begin
        logic [OW-1:0] uo_now;
        tests   = 0;
        failed  = 0;
        rst_n   = 1'b0;
        sel_in  = 3'd0;
        ui_in   = 8'h5A;
        tile_uo = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};

        // Power-on reset, then tile 0 completes its reset and runs.
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n  = 1'b1;
        prev_e = mk(K_RESET, 0);
        push(K_RESET, 0, RC - 1);
        push(K_RUN, 0, 3);
        drain();

        // Output latency on tile 0.
        tile_uo[7:0] = 8'hA5;
        #1;
`ifdef MTC_OUT_REG_EN
        uo_now = 8'h00;
`else
        uo_now = 8'hA5;
`endif
        chk("uo_same_cycle", 64'(uo_out), 64'(uo_now));
        push(K_RUN, 0, 2);
        drain();

        // Switch tile 0 -> 2.
        sel_in = 3'd2;
        push(K_RUN, 0, SS);
        push(K_QUI, 0, 1);
        push(K_RESET, 2, RC);
        push(K_RUN, 2, 3);
        drain();

        // Out-of-range request is ignored.
        ui_in  = 8'hC3;
        sel_in = 3'd7;
        push(K_RUN, 2, 6);
        drain();

        // Switch to tile 1, retarget to 3 midway through tile 1's reset.
        sel_in = 3'd1;
        push(K_RUN, 2, SS);
        push(K_QUI, 2, 1);
        push(K_RESET, 1, 2);
        drain();
        sel_in = 3'd3;
        push(K_RESET, 1, RC - 2);
        push(K_RUN, 1, 1);
        push(K_QUI, 1, 1);
        push(K_RESET, 3, RC);
        push(K_RUN, 3, 2);
        drain();

        // Reset pulse during QUIESCE aborts the switch.
        sel_in = 3'd2;
        push(K_RUN, 3, SS);
        push(K_QUI, 3, 1);
        drain();
        rst_n  = 1'b0;
        sel_in = 3'd0;
        #1;
        chk_reset();
        #1;
        rst_n  = 1'b1;
        prev_e = mk(K_RESET, 0);
        push(K_RESET, 0, RC - 1);
        push(K_RUN, 0, 3);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
